// File: rtl/gem_sync_mon_n.sv
// GEM link sync monitor: per-fiber frame-separator lock FSM with hysteresis,
// per-OH and cross-OH K-char agreement, sticky loss flags and error counters.
module gem_sync_mon_n #(
    parameter int  NFIBERS       = 4,
    parameter int  FIBERS_PER_OH = 2,
    parameter int  LOCK_THRESH   = 8,
    parameter int  UNLOCK_THRESH = 4,
    parameter int  CNT_BITS      = 16,
    localparam int NOH           = NFIBERS / FIBERS_PER_OH
) (
    input  logic                        clock,
    input  logic                        global_reset,
    input  logic                        ttc_resync,
    input  logic [8*NFIBERS-1:0]        kchar,
    input  logic [NFIBERS-1:0]          fiber_enable,
    input  logic [NFIBERS-1:0]          link_good,
    input  logic [NOH-1:0]              oh_overflow,
    input  logic [NOH-1:0]              oh_bc0marker,
    input  logic [NOH-1:0]              oh_resyncmarker,
    input  logic [NOH-1:0]              oh_sync_done,
    input  logic [4*NOH-1:0]            oh_rxd_delay,
    input  logic                        err_cnt_clr,
    output logic [NFIBERS-1:0]          fiber_locked,
    output logic [NOH-1:0]              oh_synced,
    output logic [NOH-1:0]              oh_lostsync,
    output logic                        all_synced,
    output logic                        all_lostsync,
    output logic [CNT_BITS*NFIBERS-1:0] err_cnt
);

    localparam logic [7:0] LOCK_T   = 8'(LOCK_THRESH);
    localparam logic [7:0] UNLOCK_T = 8'(UNLOCK_THRESH);
    localparam logic [7:0] SEP_BC   = 8'hBC;
    localparam logic [7:0] SEP_F7   = 8'hF7;
    localparam logic [7:0] SEP_FB   = 8'hFB;
    localparam logic [7:0] SEP_FD   = 8'hFD;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, FADE} state_t;

    function automatic logic in_table(input logic [7:0] k);
        return (k == SEP_BC) || (k == SEP_F7) || (k == SEP_FB) || (k == SEP_FD);
    endfunction

    function automatic logic [7:0] next_sep(input logic [7:0] k);
        logic [7:0] n;
        case (k)
            SEP_BC:  n = SEP_F7;
            SEP_F7:  n = SEP_FB;
            SEP_FB:  n = SEP_FD;
            default: n = SEP_BC;
        endcase
        return n;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic                rst;
    logic [NOH-1:0]      marker;
    logic [NOH-1:0]      done_dly;
    logic [15:0]         done_sr [NOH];
    logic [NFIBERS-1:0]  lg_d1;
    logic [NFIBERS-1:0]  lg_d2;
    logic [7:0]          kc      [NFIBERS];
    logic [NFIBERS-1:0]  skip;
    logic [NFIBERS-1:0]  tab;
    logic [NFIBERS-1:0]  bad;
    logic [NFIBERS-1:0]  locked_now;
    state_t              state_q [NFIBERS];
    state_t              state_d [NFIBERS];
    logic [7:0]          cnt_q   [NFIBERS];
    logic [7:0]          cnt_d   [NFIBERS];
    logic [7:0]          exp_q   [NFIBERS];
    logic [7:0]          exp_d   [NFIBERS];
    logic [CNT_BITS-1:0] err_q   [NFIBERS];
    logic [NOH-1:0]      has_en;
    logic [7:0]          first_k [NOH];
    logic [NOH-1:0]      oh_insync;
    logic                all_insync;

    assign rst = global_reset | ttc_resync;

    always_comb begin
        marker   = '0;
        done_dly = '0;
        for (int j = 0; j < NOH; j++) begin
            marker[j]   = oh_overflow[j] | oh_bc0marker[j] | oh_resyncmarker[j];
            done_dly[j] = done_sr[j][oh_rxd_delay[4*j +: 4]];
        end
    end

    // sync_done delay line and link-good history are free-running samples
    always_ff @(posedge clock) begin
        for (int j = 0; j < NOH; j++) begin
            done_sr[j] <= {done_sr[j][14:0], oh_sync_done[j]};
        end
        lg_d1 <= link_good;
        lg_d2 <= lg_d1;
    end

    always_comb begin
        for (int i = 0; i < NFIBERS; i++) begin
            kc[i]         = kchar[8*i +: 8];
            locked_now[i] = (state_q[i] == LOCKED) || (state_q[i] == FADE);
        end
    end

    // Per-fiber separator check and lock FSM next state
    always_comb begin
        skip = '0;
        tab  = '0;
        bad  = '0;
        for (int i = 0; i < NFIBERS; i++) begin
            skip[i] = marker[i / FIBERS_PER_OH] | ~link_good[i] | ~lg_d2[i] | ~fiber_enable[i];
            tab[i]  = in_table(kc[i]);
            bad[i]  = ~skip[i] & ~(tab[i] & (kc[i] == exp_q[i]));

            // a marker cycle still consumes one separator slot
            exp_d[i] = exp_q[i];
            if (~skip[i] | marker[i / FIBERS_PER_OH]) begin
                exp_d[i] = tab[i] ? next_sep(kc[i]) : next_sep(exp_q[i]);
            end

            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (~skip[i]) begin
                case (state_q[i])
                    HUNT: begin
                        if (tab[i]) begin
                            if (LOCK_T <= 8'd1) begin
                                state_d[i] = LOCKED;
                            end else begin
                                state_d[i] = VERIFY;
                                cnt_d[i]   = 8'd1;
                            end
                        end
                    end
                    VERIFY: begin
                        if (bad[i]) begin
                            state_d[i] = HUNT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                            if (cnt_d[i] >= LOCK_T) state_d[i] = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (bad[i]) begin
                            if (UNLOCK_T <= 8'd1) begin
                                state_d[i] = HUNT;
                            end else begin
                                state_d[i] = FADE;
                                cnt_d[i]   = 8'd1;
                            end
                        end
                    end
                    FADE: begin
                        if (bad[i]) begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                            if (cnt_d[i] >= UNLOCK_T) state_d[i] = HUNT;
                        end else begin
                            state_d[i] = LOCKED;
                        end
                    end
                    default: state_d[i] = HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < NFIBERS; i++) begin
                state_q[i] <= HUNT;
                cnt_q[i]   <= 8'd0;
                exp_q[i]   <= SEP_BC;
                err_q[i]   <= '0;
            end
            fiber_locked <= '0;
        end else begin
            for (int i = 0; i < NFIBERS; i++) begin
                state_q[i]      <= state_d[i];
                cnt_q[i]        <= cnt_d[i];
                exp_q[i]        <= exp_d[i];
                fiber_locked[i] <= (state_d[i] == LOCKED) || (state_d[i] == FADE);
                if (err_cnt_clr) begin
                    err_q[i] <= '0;
                end else if (bad[i] && locked_now[i]) begin
                    err_q[i] <= sat_inc(err_q[i]);
                end
            end
        end
    end

    always_comb begin
        err_cnt = '0;
        for (int i = 0; i < NFIBERS; i++) begin
            err_cnt[CNT_BITS*i +: CNT_BITS] = err_q[i];
        end
    end

    // Per-OH agreement among enabled, participating fibers
    always_comb begin : oh_cmp
        logic       found;
        logic       ok;
        logic [7:0] rk;
        int         idx;
        has_en    = '0;
        oh_insync = '0;
        found     = 1'b0;
        ok        = 1'b1;
        rk        = 8'h00;
        idx       = 0;
        for (int j = 0; j < NOH; j++) begin
            first_k[j] = 8'h00;
            found      = 1'b0;
            ok         = 1'b1;
            rk         = 8'h00;
            for (int f = 0; f < FIBERS_PER_OH; f++) begin
                idx = j * FIBERS_PER_OH + f;
                if (fiber_enable[idx]) begin
                    if (!has_en[j]) first_k[j] = kc[idx];
                    has_en[j] = 1'b1;
                    if (!skip[idx]) begin
                        if (!locked_now[idx] || bad[idx]) ok = 1'b0;
                        if (!found) begin
                            found = 1'b1;
                            rk    = kc[idx];
                        end else if (kc[idx] != rk) begin
                            ok = 1'b0;
                        end
                    end
                end
            end
            oh_insync[j] = ~has_en[j] | marker[j] | ok;
        end
    end

    always_comb begin : all_cmp
        logic       found;
        logic       ok;
        logic [7:0] rk;
        found = 1'b0;
        ok    = 1'b1;
        rk    = 8'h00;
        for (int j = 0; j < NOH; j++) begin
            if (!oh_insync[j]) ok = 1'b0;
            if (has_en[j]) begin
                if (!found) begin
                    found = 1'b1;
                    rk    = first_k[j];
                end else if (first_k[j] != rk) begin
                    ok = 1'b0;
                end
            end
        end
        all_insync = ok | (|marker);
    end

    // Registered sync status; held benign until the delayed sync_done arrives
    always_ff @(posedge clock) begin
        for (int j = 0; j < NOH; j++) begin
            if (rst || !done_dly[j]) begin
                oh_synced[j]   <= 1'b1;
                oh_lostsync[j] <= 1'b0;
            end else begin
                oh_synced[j]   <= oh_insync[j];
                oh_lostsync[j] <= oh_lostsync[j] | ~oh_insync[j];
            end
        end
        if (rst || !(&done_dly)) begin
            all_synced   <= 1'b1;
            all_lostsync <= 1'b0;
        end else begin
            all_synced   <= all_insync;
            all_lostsync <= all_lostsync | ~all_insync;
        end
    end

endmodule

// File: tb/tb_gem_sync_mon_n.sv
// Directed bench for gem_sync_mon_n: 4 fibers in 2 OHs, 8-bit error counters.
module tb_gem_sync_mon_n;

    logic        clock = 1'b0;
    logic        global_reset;
    logic        ttc_resync;
    logic [31:0] kchar;
    logic [3:0]  fiber_enable;
    logic [3:0]  link_good;
    logic [1:0]  oh_overflow;
    logic [1:0]  oh_bc0marker;
    logic [1:0]  oh_resyncmarker;
    logic [1:0]  oh_sync_done;
    logic [7:0]  oh_rxd_delay;
    logic        err_cnt_clr;
    logic [3:0]  fiber_locked;
    logic [1:0]  oh_synced;
    logic [1:0]  oh_lostsync;
    logic        all_synced;
    logic        all_lostsync;
    logic [31:0] err_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         p        = 0;
    int         lag1     = 0;
    logic [3:0] ovr_en   = 4'b0000;
    logic [7:0] ovr [4];

    always #5 clock = ~clock;

    gem_sync_mon_n #(
        .NFIBERS(4), .FIBERS_PER_OH(2), .LOCK_THRESH(8),
        .UNLOCK_THRESH(4), .CNT_BITS(8)
    ) dut (
        .clock(clock), .global_reset(global_reset), .ttc_resync(ttc_resync),
        .kchar(kchar), .fiber_enable(fiber_enable), .link_good(link_good),
        .oh_overflow(oh_overflow), .oh_bc0marker(oh_bc0marker),
        .oh_resyncmarker(oh_resyncmarker), .oh_sync_done(oh_sync_done),
        .oh_rxd_delay(oh_rxd_delay), .err_cnt_clr(err_cnt_clr),
        .fiber_locked(fiber_locked), .oh_synced(oh_synced),
        .oh_lostsync(oh_lostsync), .all_synced(all_synced),
        .all_lostsync(all_lostsync), .err_cnt(err_cnt)
    );

    function automatic logic [7:0] sep(input int v);
        logic [7:0] s;
        case (v % 4)
            0:       s = 8'hBC;
            1:       s = 8'hF7;
            2:       s = 8'hFB;
            default: s = 8'hFD;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // OH1 fibers lag OH0 by lag1 separators; ovr_en overrides single fibers
    task automatic rot_tick();
        for (int i = 0; i < 4; i++) begin
            kchar[8*i +: 8] = ovr_en[i] ? ovr[i] : sep(p + ((i >= 2) ? 4 - lag1 : 0));
        end
        @(posedge clock);
        #1;
        p++;
    endtask

    task automatic pulse_resync();
        oh_sync_done = 2'b00;
        ttc_resync   = 1'b1;
        rot_tick();
        ttc_resync   = 1'b0;
    endtask

    task automatic lock_all();
        repeat (8) rot_tick();
        oh_sync_done = 2'b11;
        repeat (2) rot_tick();
    endtask

    initial begin
        global_reset    = 1'b1;
        ttc_resync      = 1'b0;
        kchar           = '0;
        fiber_enable    = 4'hF;
        link_good       = 4'hF;
        oh_overflow     = 2'b00;
        oh_bc0marker    = 2'b00;
        oh_resyncmarker = 2'b00;
        oh_sync_done    = 2'b00;
        oh_rxd_delay    = 8'h00;
        err_cnt_clr     = 1'b0;
        for (int i = 0; i < 4; i++) ovr[i] = 8'h00;

        repeat (20) rot_tick();
        chk("rst_locked",   fiber_locked, 4'h0);
        chk("rst_ohsync",   oh_synced,    2'b11);
        chk("rst_ohlost",   oh_lostsync,  2'b00);
        chk("rst_allsync",  all_synced,   1'b1);
        chk("rst_alllost",  all_lostsync, 1'b0);
        chk("rst_errcnt",   err_cnt,      32'h0);

        global_reset = 1'b0;
        repeat (7) rot_tick();
        chk("lock_7th", fiber_locked, 4'h0);
        rot_tick();
        chk("lock_8th", fiber_locked, 4'hF);
        oh_sync_done = 2'b11;
        repeat (2) rot_tick();
        chk("clean_ohsync",  oh_synced,    2'b11);
        chk("clean_ohlost",  oh_lostsync,  2'b00);
        chk("clean_allsync", all_synced,   1'b1);
        chk("clean_alllost", all_lostsync, 1'b0);
        chk("clean_err",     err_cnt,      32'h0);

        // marker cycle with a garbage kchar: skipped, no error
        oh_bc0marker = 2'b01;
        ovr_en       = 4'b0001;
        ovr[0]       = 8'h00;
        rot_tick();
        oh_bc0marker = 2'b00;
        ovr_en       = 4'b0000;
        chk("mark_err",    err_cnt,      32'h0);
        chk("mark_ohsync", oh_synced,    2'b11);
        chk("mark_all",    all_synced,   1'b1);
        rot_tick();
        chk("mark_after_err",  err_cnt,     32'h0);
        chk("mark_after_lock", fiber_locked, 4'hF);
        chk("mark_after_lost", oh_lostsync, 2'b00);

        while ((p % 4) != 1) rot_tick();
        ovr_en = 4'b0010;
        ovr[1] = 8'hFE;
        rot_tick();
        ovr_en = 4'b0000;
        chk("fe_err",     err_cnt,      32'h0000_0100);
        chk("fe_lock",    fiber_locked, 4'hF);
        chk("fe_ohsync",  oh_synced,    2'b10);
        chk("fe_ohlost",  oh_lostsync,  2'b01);
        chk("fe_alllost", all_lostsync, 1'b1);
        rot_tick();
        chk("fe2_ohsync", oh_synced,    2'b11);
        chk("fe2_ohlost", oh_lostsync,  2'b01);
        chk("fe2_lock",   fiber_locked, 4'hF);
        chk("fe2_err",    err_cnt,      32'h0000_0100);

        pulse_resync();
        chk("rsy_locked",  fiber_locked, 4'h0);
        chk("rsy_err",     err_cnt,      32'h0);
        chk("rsy_ohsync",  oh_synced,    2'b11);
        chk("rsy_ohlost",  oh_lostsync,  2'b00);
        chk("rsy_allsync", all_synced,   1'b1);
        chk("rsy_alllost", all_lostsync, 1'b0);
        lock_all();
        chk("relock", fiber_locked, 4'hF);

        ovr_en = 4'b0100;
        ovr[2] = 8'h00;
        repeat (3) rot_tick();
        chk("unl_3rd", fiber_locked, 4'hF);
        rot_tick();
        chk("unl_4th", fiber_locked, 4'b1011);
        chk("unl_err", err_cnt,      32'h0004_0000);
        ovr_en = 4'b0000;
        repeat (7) rot_tick();
        chk("unl_relock7", fiber_locked, 4'b1011);
        rot_tick();
        chk("unl_relock8", fiber_locked, 4'hF);
        chk("unl_err_hold", err_cnt,     32'h0004_0000);

        lag1 = 1;
        pulse_resync();
        lock_all();
        chk("lag_lock",    fiber_locked, 4'hF);
        chk("lag_ohsync",  oh_synced,    2'b11);
        chk("lag_ohlost",  oh_lostsync,  2'b00);
        chk("lag_allsync", all_synced,   1'b0);
        chk("lag_alllost", all_lostsync, 1'b1);
        lag1 = 0;

        oh_rxd_delay = 8'h03;
        pulse_resync();
        repeat (8) rot_tick();
        oh_sync_done = 2'b11;
        ovr_en       = 4'b0001;
        ovr[0]       = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            rot_tick();
            chk($sformatf("dly_hold%0d", k), oh_synced[0], 1'b1);
        end
        rot_tick();
        chk("dly_release", oh_synced[0],   1'b0);
        chk("dly_lost",    oh_lostsync[0], 1'b1);
        ovr_en       = 4'b0000;
        oh_rxd_delay = 8'h00;

        pulse_resync();
        lock_all();
        for (int g = 0; g < 85; g++) begin
            ovr_en = 4'b1000;
            ovr[3] = 8'h00;
            repeat (3) rot_tick();
            ovr_en = 4'b0000;
            rot_tick();
        end
        chk("sat_full", {24'h0, err_cnt[31:24]}, 32'hFF);
        chk("sat_lock", fiber_locked, 4'hF);
        ovr_en = 4'b1000;
        rot_tick();
        chk("sat_hold", {24'h0, err_cnt[31:24]}, 32'hFF);
        err_cnt_clr = 1'b1;
        rot_tick();
        err_cnt_clr = 1'b0;
        chk("clr_wins", err_cnt, 32'h0);
        rot_tick();
        chk("clr_resume", err_cnt, 32'h0100_0000);
        ovr_en = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
